// File: rtl/ant_move_sequencer_if.sv
// World-cell memory bus between the ant move sequencer (master) and the cell store (slave).
// Read data is {sugar, signal} and arrives one cycle after the read strobe.
interface ant_move_sequencer_if #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int SUGAR_bits  = 4,
    parameter int SIGNAL_bits = 8
);
    logic                              mem_rd_en;
    logic [X_bits-1:0]                 mem_rd_x;
    logic [Y_bits-1:0]                 mem_rd_y;
    logic [SUGAR_bits+SIGNAL_bits-1:0] mem_rd_data;
    logic                              mem_wr_en;
    logic [X_bits-1:0]                 mem_wr_x;
    logic [Y_bits-1:0]                 mem_wr_y;
    logic [SUGAR_bits+SIGNAL_bits-1:0] mem_wr_data;

    modport master (
        output mem_rd_en,
        output mem_rd_x,
        output mem_rd_y,
        input  mem_rd_data,
        output mem_wr_en,
        output mem_wr_x,
        output mem_wr_y,
        output mem_wr_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_x,
        input  mem_rd_y,
        output mem_rd_data,
        input  mem_wr_en,
        input  mem_wr_x,
        input  mem_wr_y,
        input  mem_wr_data
    );
endinterface

// File: rtl/ant_move_sequencer.sv
// Round controller: serves each ant in turn by reading its cell and 8 neighbours,
// strobing moveNow, then writing back the updated cell; re-arms all ants at round end.
module ant_move_sequencer #(
    parameter int N_ANTS      = 8,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int SIGNAL_bits = 8,
    parameter int SUGAR_bits  = 4,
    parameter int DEPOSIT     = 32,
    localparam int ANT_IDX_bits = (N_ANTS > 1) ? $clog2(N_ANTS) : 1
) (
    input  logic                         game_clk,
    input  logic                         RESET,
    input  logic                         start,
    output logic                         busy,
    output logic                         round_done,
    output logic [ANT_IDX_bits-1:0]      ant_sel,
    input  logic [X_bits-1:0]            ant_X,
    input  logic [Y_bits-1:0]            ant_Y,
    input  logic                         ant_mouthFull,
    input  logic                         ant_collecting,
    input  logic                         ant_dropping,
    output logic                         moveNow,
    output logic                         global_writing_flag,
    output logic [7:0][SIGNAL_bits-1:0]  surrounding_signals,
    output logic                         onSugar,
    ant_move_sequencer_if.master         mem
);

    localparam int CELL_bits = SUGAR_bits + SIGNAL_bits;
    localparam int unsigned SIG_MAX    = (1 << SIGNAL_bits) - 1;
    localparam int unsigned DEP_CLAMP  = (DEPOSIT > SIG_MAX) ? SIG_MAX : DEPOSIT;
    localparam logic [SIGNAL_bits:0] DEPOSIT_W = (SIGNAL_bits+1)'(DEP_CLAMP);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        CAPTURE,
        MOVE,
        WRITE,
        FLAG
    } state_t;

    state_t                         state;
    state_t                         next_state;
    logic                           init_armed;
    logic [3:0]                     rd_idx;
    logic [X_bits-1:0]              old_x;
    logic [Y_bits-1:0]              old_y;
    logic [X_bits-1:0]              step_x;
    logic [Y_bits-1:0]              step_y;
    logic [CELL_bits-1:0]           centre_buf;
    logic [6:0][SIGNAL_bits-1:0]    nb_buf;
    logic [SUGAR_bits-1:0]          cell_sugar;
    logic [SIGNAL_bits-1:0]         cell_signal;
    logic                           flag_mouth;
    logic                           flag_collect;
    logic                           flag_drop;
    logic                           last_ant;
    logic                           rd_en;
    logic                           wr_en;
    logic [SIGNAL_bits:0]           signal_sum;
    logic [SUGAR_bits-1:0]          sugar_next;
    logic [SIGNAL_bits-1:0]         signal_next;

    assign last_ant = (ant_sel == ANT_IDX_bits'(N_ANTS - 1));
    assign onSugar  = (cell_sugar != '0);

    // init_armed holds INIT for one extra edge so the re-arm strobe appears only after release.
    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            state      <= INIT;
            init_armed <= 1'b0;
        end else begin
            state      <= next_state;
            init_armed <= 1'b1;
        end
    end

    always_comb begin
        next_state          = state;
        busy                = 1'b0;
        round_done          = 1'b0;
        moveNow             = 1'b0;
        global_writing_flag = 1'b0;
        rd_en               = 1'b0;
        wr_en               = 1'b0;
        case (state)
            INIT: begin
                global_writing_flag = init_armed;
                if (init_armed) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (start) begin
                    next_state = READ;
                end
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (rd_idx == 4'd8) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                busy       = 1'b1;
                next_state = MOVE;
            end
            MOVE: begin
                busy       = 1'b1;
                moveNow    = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                next_state = last_ant ? FLAG : READ;
            end
            FLAG: begin
                busy                = 1'b1;
                round_done          = 1'b1;
                global_writing_flag = 1'b1;
                next_state          = IDLE;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            ant_sel      <= '0;
            rd_idx       <= '0;
            old_x        <= '0;
            old_y        <= '0;
            flag_mouth   <= 1'b0;
            flag_collect <= 1'b0;
            flag_drop    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ant_sel <= '0;
                        rd_idx  <= '0;
                    end
                end
                READ: begin
                    rd_idx <= rd_idx + 4'd1;
                    if (rd_idx == 4'd0) begin
                        old_x <= ant_X;
                        old_y <= ant_Y;
                    end
                end
                MOVE: begin
                    flag_mouth   <= ant_mouthFull;
                    flag_collect <= ant_collecting;
                    flag_drop    <= ant_dropping;
                end
                WRITE: begin
                    rd_idx <= '0;
                    if (!last_ant) begin
                        ant_sel <= ant_sel + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Data returned in READ belongs to the read issued one cycle earlier (index rd_idx-1);
    // the last neighbour lands in CAPTURE, where the whole view is published at once.
    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            centre_buf          <= '0;
            nb_buf              <= '0;
            cell_sugar          <= '0;
            cell_signal         <= '0;
            surrounding_signals <= '0;
        end else begin
            if (state == READ && rd_idx != 4'd0) begin
                if (rd_idx == 4'd1) begin
                    centre_buf <= mem.mem_rd_data;
                end else begin
                    nb_buf[3'(rd_idx - 4'd2)] <= mem.mem_rd_data[SIGNAL_bits-1:0];
                end
            end
            if (state == CAPTURE) begin
                surrounding_signals <= {mem.mem_rd_data[SIGNAL_bits-1:0], nb_buf};
                cell_sugar          <= centre_buf[CELL_bits-1:SIGNAL_bits];
                cell_signal         <= centre_buf[SIGNAL_bits-1:0];
            end
        end
    end

    always_comb begin
        step_x = '0;
        step_y = '0;
        case (rd_idx)
            4'd1: begin
                step_y = '1;
            end
            4'd2: begin
                step_x = X_bits'(1);
                step_y = '1;
            end
            4'd3: begin
                step_x = X_bits'(1);
            end
            4'd4: begin
                step_x = X_bits'(1);
                step_y = Y_bits'(1);
            end
            4'd5: begin
                step_y = Y_bits'(1);
            end
            4'd6: begin
                step_x = '1;
                step_y = Y_bits'(1);
            end
            4'd7: begin
                step_x = '1;
            end
            4'd8: begin
                step_x = '1;
                step_y = '1;
            end
            default: begin
            end
        endcase
    end

    // Dropping leaves the cell untouched; nest bookkeeping lives elsewhere.
    always_comb begin
        signal_sum  = {1'b0, cell_signal} + DEPOSIT_W;
        sugar_next  = cell_sugar;
        signal_next = cell_signal;
        if (!flag_drop) begin
            if (flag_collect && cell_sugar != '0) begin
                sugar_next = cell_sugar - 1'b1;
            end
            if (flag_mouth || flag_collect) begin
                signal_next = signal_sum[SIGNAL_bits] ? '1 : signal_sum[SIGNAL_bits-1:0];
            end
        end
    end

    always_comb begin
        mem.mem_rd_en   = rd_en;
        mem.mem_rd_x    = '0;
        mem.mem_rd_y    = '0;
        mem.mem_wr_en   = wr_en;
        mem.mem_wr_x    = '0;
        mem.mem_wr_y    = '0;
        mem.mem_wr_data = '0;
        if (rd_en) begin
            if (rd_idx == 4'd0) begin
                mem.mem_rd_x = ant_X;
                mem.mem_rd_y = ant_Y;
            end else begin
                mem.mem_rd_x = old_x + step_x;
                mem.mem_rd_y = old_y + step_y;
            end
        end
        if (wr_en) begin
            mem.mem_wr_x    = old_x;
            mem.mem_wr_y    = old_y;
            mem.mem_wr_data = {sugar_next, signal_next};
        end
    end

endmodule

// File: tb/tb_ant_move_sequencer.sv
// Directed bench for ant_move_sequencer with two ants, a behavioural world memory
// and hand-computed expectations for cycle schedule, addresses and write-back data.
module tb_ant_move_sequencer;

    localparam int N_ANTS      = 2;
    localparam int X_bits      = 8;
    localparam int Y_bits      = 8;
    localparam int SIGNAL_bits = 8;
    localparam int SUGAR_bits  = 4;
    localparam int DEPOSIT     = 32;

    logic                    game_clk = 1'b0;
    logic                    RESET    = 1'b1;
    logic                    start    = 1'b0;
    logic                    busy;
    logic                    round_done;
    logic [0:0]              ant_sel;
    logic [7:0]              ant_X;
    logic [7:0]              ant_Y;
    logic                    ant_mouthFull;
    logic                    ant_collecting;
    logic                    ant_dropping;
    logic                    moveNow;
    logic                    global_writing_flag;
    logic [7:0][7:0]         surrounding_signals;
    logic                    onSugar;

    logic [7:0]              ant_x_tab [2];
    logic [7:0]              ant_y_tab [2];
    logic [2:0]              ant_flag_tab [2];

    logic                    pre_en   = 1'b0;
    logic [7:0]              pre_x    = '0;
    logic [7:0]              pre_y    = '0;
    logic [11:0]             pre_data = '0;
    logic [11:0]             world [65536] = '{default: 12'h000};

    int assert_count = 0;
    int fail_count   = 0;

    ant_move_sequencer_if #(
        .X_bits(X_bits), .Y_bits(Y_bits), .SUGAR_bits(SUGAR_bits), .SIGNAL_bits(SIGNAL_bits)
    ) mem_bus ();

    ant_move_sequencer #(
        .N_ANTS(N_ANTS), .X_bits(X_bits), .Y_bits(Y_bits),
        .SIGNAL_bits(SIGNAL_bits), .SUGAR_bits(SUGAR_bits), .DEPOSIT(DEPOSIT)
    ) dut (
        .game_clk            (game_clk),
        .RESET               (RESET),
        .start               (start),
        .busy                (busy),
        .round_done          (round_done),
        .ant_sel             (ant_sel),
        .ant_X               (ant_X),
        .ant_Y               (ant_Y),
        .ant_mouthFull       (ant_mouthFull),
        .ant_collecting      (ant_collecting),
        .ant_dropping        (ant_dropping),
        .moveNow             (moveNow),
        .global_writing_flag (global_writing_flag),
        .surrounding_signals (surrounding_signals),
        .onSugar             (onSugar),
        .mem                 (mem_bus)
    );

    always #5 game_clk = ~game_clk;

    // External ant mux selected by ant_sel; flag table is {mouthFull, collecting, dropping}.
    assign ant_X          = ant_x_tab[ant_sel];
    assign ant_Y          = ant_y_tab[ant_sel];
    assign ant_mouthFull  = ant_flag_tab[ant_sel][2];
    assign ant_collecting = ant_flag_tab[ant_sel][1];
    assign ant_dropping   = ant_flag_tab[ant_sel][0];

    always @(posedge game_clk) begin
        if (pre_en) world[{pre_y, pre_x}] <= pre_data;
        if (mem_bus.mem_wr_en) world[{mem_bus.mem_wr_y, mem_bus.mem_wr_x}] <= mem_bus.mem_wr_data;
        if (mem_bus.mem_rd_en) mem_bus.mem_rd_data <= world[{mem_bus.mem_rd_y, mem_bus.mem_rd_x}];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge game_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s);
        start = s;
    endtask

    task automatic preload(input logic [7:0] x, input logic [7:0] y, input logic [11:0] d);
        pre_en   = 1'b1;
        pre_x    = x;
        pre_y    = y;
        pre_data = d;
        nextCycle();
        pre_en   = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".busy"},       64'(busy), 64'd0);
        checkOutput({tag, ".round_done"}, 64'(round_done), 64'd0);
        checkOutput({tag, ".moveNow"},    64'(moveNow), 64'd0);
        checkOutput({tag, ".gwf"},        64'(global_writing_flag), 64'd0);
        checkOutput({tag, ".rd_en"},      64'(mem_bus.mem_rd_en), 64'd0);
        checkOutput({tag, ".wr_en"},      64'(mem_bus.mem_wr_en), 64'd0);
        checkOutput({tag, ".ant_sel"},    64'(ant_sel), 64'd0);
        checkOutput({tag, ".rd_addr"},    64'({mem_bus.mem_rd_y, mem_bus.mem_rd_x}), 64'd0);
        checkOutput({tag, ".wr_addr"},    64'({mem_bus.mem_wr_y, mem_bus.mem_wr_x}), 64'd0);
        checkOutput({tag, ".wr_data"},    64'(mem_bus.mem_wr_data), 64'd0);
        checkOutput({tag, ".surround"},   64'(surrounding_signals), 64'd0);
        checkOutput({tag, ".onSugar"},    64'(onSugar), 64'd0);
    endtask

    // Two-ant round: READ 1-9/13-21, MOVE 11/23, WRITE 12/24, FLAG 25, idle at 26.
    task automatic checkSchedule(input int r, input int c);
        logic e_busy, e_rd, e_wr, e_move, e_flag;
        e_busy = (c >= 1 && c <= 25);
        e_rd   = (c >= 1 && c <= 9) || (c >= 13 && c <= 21);
        e_wr   = (c == 12) || (c == 24);
        e_move = (c == 11) || (c == 23);
        e_flag = (c == 25);
        checkOutput($sformatf("r%0d.busy@%0d", r, c),  64'(busy), 64'(e_busy));
        checkOutput($sformatf("r%0d.rd_en@%0d", r, c), 64'(mem_bus.mem_rd_en), 64'(e_rd));
        checkOutput($sformatf("r%0d.wr_en@%0d", r, c), 64'(mem_bus.mem_wr_en), 64'(e_wr));
        checkOutput($sformatf("r%0d.move@%0d", r, c),  64'(moveNow), 64'(e_move));
        checkOutput($sformatf("r%0d.gwf@%0d", r, c),   64'(global_writing_flag), 64'(e_flag));
        checkOutput($sformatf("r%0d.done@%0d", r, c),  64'(round_done), 64'(e_flag));
    endtask

    task automatic checkRead(input string tag, input logic [7:0] x, input logic [7:0] y);
        checkOutput({tag, ".rd_addr"}, 64'({mem_bus.mem_rd_y, mem_bus.mem_rd_x}), 64'({y, x}));
    endtask

    task automatic checkWrite(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [11:0] d);
        checkOutput({tag, ".wr_addr"}, 64'({mem_bus.mem_wr_y, mem_bus.mem_wr_x}), 64'({y, x}));
        checkOutput({tag, ".wr_data"}, 64'(mem_bus.mem_wr_data), 64'(d));
    endtask

    task automatic checkPoints(input int r, input int c);
        if (r == 0) begin
            case (c)
                1:  begin checkRead("A.c1", 8'd5, 8'd5); checkOutput("A.sel@1", 64'(ant_sel), 64'd0); end
                2:  checkRead("A.c2N", 8'd5, 8'd4);
                3:  checkRead("A.c3NE", 8'd6, 8'd4);
                4:  checkRead("A.c4E", 8'd6, 8'd5);
                11: begin
                    checkOutput("A.surround2", 64'(surrounding_signals[2]), 64'h40);
                    checkOutput("A.onSugar0", 64'(onSugar), 64'd1);
                end
                12: checkWrite("A.wr0", 8'd5, 8'd5, 12'h2FF);
                13: begin checkRead("A.c13", 8'd0, 8'd0); checkOutput("A.sel@13", 64'(ant_sel), 64'd1); end
                14: checkRead("A.wrapN", 8'd0, 8'd255);
                21: checkRead("A.wrapNW", 8'd255, 8'd255);
                22: checkOutput("A.hold", 64'(surrounding_signals), 64'h0000000000400000);
                23: begin
                    checkOutput("A.surround1", 64'(surrounding_signals), 64'h7700000000000055);
                    checkOutput("A.onSugar1", 64'(onSugar), 64'd0);
                end
                24: checkWrite("A.wr1", 8'd0, 8'd0, 12'h010);
                26: checkOutput("A.sel@26", 64'(ant_sel), 64'd1);
                default: ;
            endcase
        end else begin
            case (c)
                11: begin
                    checkOutput("B.surround2", 64'(surrounding_signals[2]), 64'h10);
                    checkOutput("B.onSugar0", 64'(onSugar), 64'd0);
                end
                12: checkWrite("B.wr0", 8'd40, 8'd40, 12'h030);
                23: checkOutput("B.surround6", 64'(surrounding_signals[6]), 64'h30);
                24: checkWrite("B.wr1", 8'd41, 8'd40, 12'h010);
                default: ;
            endcase
        end
    endtask

    task automatic runRound(input int r, input int start_hold);
        applyStimulus(1'b1);
        nextCycle();
        if (start_hold == 0) applyStimulus(1'b0);
        for (int c = 1; c <= 26; c++) begin
            checkSchedule(r, c);
            checkPoints(r, c);
            if (c == start_hold) applyStimulus(1'b0);
            nextCycle();
        end
    endtask

    initial begin
        ant_x_tab[0] = 8'd5;  ant_y_tab[0] = 8'd5;  ant_flag_tab[0] = 3'b010;
        ant_x_tab[1] = 8'd0;  ant_y_tab[1] = 8'd0;  ant_flag_tab[1] = 3'b001;

        nextCycle();
        nextCycle();
        checkResetValues("reset");
        RESET = 1'b0;
        nextCycle();
        checkOutput("init.gwf", 64'(global_writing_flag), 64'd1);
        checkOutput("init.busy", 64'(busy), 64'd0);
        checkOutput("init.move", 64'(moveNow), 64'd0);
        nextCycle();
        checkOutput("idle.gwf", 64'(global_writing_flag), 64'd0);
        checkOutput("idle.busy", 64'(busy), 64'd0);

        preload(8'd5, 8'd5, 12'h3F0);
        preload(8'd6, 8'd5, 12'h040);
        preload(8'd0, 8'd0, 12'h010);
        preload(8'd0, 8'd255, 12'h055);
        preload(8'd255, 8'd255, 12'h077);
        runRound(0, 0);

        ant_x_tab[0] = 8'd40; ant_y_tab[0] = 8'd40; ant_flag_tab[0] = 3'b100;
        ant_x_tab[1] = 8'd41; ant_y_tab[1] = 8'd40; ant_flag_tab[1] = 3'b000;
        preload(8'd40, 8'd40, 12'h010);
        preload(8'd41, 8'd40, 12'h010);
        runRound(1, 20);

        applyStimulus(1'b1);
        nextCycle();
        applyStimulus(1'b0);
        for (int c = 1; c <= 14; c++) begin
            checkSchedule(2, c);
            nextCycle();
        end
        RESET = 1'b1;
        #1;
        checkResetValues("abort");
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkOutput($sformatf("abort.wr_en%0d", k), 64'(mem_bus.mem_wr_en), 64'd0);
            checkOutput($sformatf("abort.gwf%0d", k), 64'(global_writing_flag), 64'd0);
        end
        RESET = 1'b0;
        nextCycle();
        checkOutput("reinit.gwf", 64'(global_writing_flag), 64'd1);
        checkOutput("reinit.wr_en", 64'(mem_bus.mem_wr_en), 64'd0);
        nextCycle();
        checkOutput("reidle.gwf", 64'(global_writing_flag), 64'd0);
        checkOutput("reidle.busy", 64'(busy), 64'd0);
        checkOutput("abort.cell", 64'(world[{8'd40, 8'd41}]), 64'h010);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ant_move_sequencer.md
# ant_move_sequencer

Round controller that serves the ant array one ant at a time from the world-cell memory. For each ant it reads the ant's cell and its 8 neighbours, presents `surrounding_signals` and `onSugar` to the ant, and pulses `moveNow`. It then captures the ant's sugar pickup and drop flags and writes the updated cell back. After the last ant it raises `global_writing_flag` so every ant re-arms for the next round. It sits between the game tick source, the ant instances (selected by an external mux on `ant_sel`) and the world memory.

## Interface
- N_ANTS, 8, number of ants served per round (≥1); ANT_IDX_bits = $clog2(N_ANTS), minimum 1
- X_bits, 8, grid X width; the grid is toroidal, 2^X_bits columns
- Y_bits, 8, grid Y width; 2^Y_bits rows
- SIGNAL_bits, 8, pheromone width
- SUGAR_bits, 4, per-cell sugar count width
- DEPOSIT, 32, pheromone added per carrying ant per move
- game_clk in 1 clock, all logic rising-edge
- RESET in 1 asynchronous, active-high
- start in 1 begin round (sampled in IDLE only)
- busy out 1 round in progress
- round_done out 1 one-cycle pulse at round end
- ant_sel out ANT_IDX_bits index of ant being served
- ant_X in X_bits, ant_Y in Y_bits: selected ant position
- ant_mouthFull, ant_collecting, ant_dropping in 1 each: selected ant flags
- moveNow out 1 one-cycle move strobe
- global_writing_flag out 1 one-cycle re-arm strobe
- surrounding_signals out 8×SIGNAL_bits neighbour pheromone, index = direction
- onSugar out 1 centre cell sugar ≠ 0
- mem_rd_en out 1; mem_rd_x out X_bits; mem_rd_y out Y_bits
- mem_rd_data in SUGAR_bits+SIGNAL_bits {sugar, signal}, valid 1 cycle after mem_rd_en
- mem_wr_en out 1; mem_wr_x, mem_wr_y out; mem_wr_data out {sugar, signal}

## Operation
- States: INIT, IDLE, READ, CAPTURE, MOVE, WRITE, FLAG.
- INIT is entered on reset. It lasts 1 cycle with global_writing_flag=1, then goes to IDLE. Ants leave reset waiting for a write strobe.
- IDLE: start=1 → READ, ant_sel=0, busy=1.
- READ: 9 cycles, mem_rd_en=1, read index r=0..8.
  - r=0 reads the centre (ant_X, ant_Y). Centre X/Y are latched into old_X/old_Y at r=0.
  - r=1..8 read direction d=r-1 at old position + offset.
  - Offsets, wrapping mod 2^bits: 0 N(0,-1), 1 NE(+1,-1), 2 E(+1,0), 3 SE(+1,+1), 4 S(0,+1), 5 SW(-1,+1), 6 W(-1,0), 7 NW(-1,-1).
- CAPTURE: 1 cycle, takes the final read data.
  - Returned data is stored as: centre → cell_sugar/cell_signal; neighbour d → surrounding_signals[d].
  - onSugar = (cell_sugar ≠ 0).
- MOVE: 1 cycle, moveNow=1. ant_mouthFull, ant_collecting and ant_dropping are sampled this cycle, which is pre-move.
- WRITE: 1 cycle, mem_wr_en=1 at old_X/old_Y.
  - sugar = cell_sugar−1 if collecting and cell_sugar≠0, else unchanged.
  - signal = cell_signal+DEPOSIT, saturating at all-ones, if mouthFull or collecting; else unchanged.
  - dropping writes the cell unchanged. Nest accounting is outside this block.
- After WRITE: if ant_sel < N_ANTS−1, increment ant_sel and go to READ. Otherwise go to FLAG.
- FLAG: 1 cycle. global_writing_flag=1, round_done=1, busy=0 on the next cycle. Next state IDLE; ant_sel stays at its last value.
- start outside IDLE is ignored.
- surrounding_signals and onSugar hold from CAPTURE until the next CAPTURE.

## Timing
- Reset values: busy 0, round_done 0, moveNow 0, global_writing_flag 0 (asserts in INIT on the first cycle after release), mem_rd_en 0, mem_wr_en 0, ant_sel 0, all addresses 0, surrounding_signals 0, onSugar 0.
- Memory read latency is exactly 1 cycle. A write in cycle t is visible to a read issued at t+1, so the next ant sees the previous ant's update.
- Taking start sampled at edge 0:
  - READ occupies cycles 1–9.
  - CAPTURE is cycle 10; surrounding_signals is valid from cycle 11.
  - MOVE is cycle 11; WRITE is cycle 12.
  - The next ant's READ starts at cycle 13, so each ant takes 12 cycles.
  - FLAG is at cycle 12·N_ANTS+1. Round latency is 12·N_ANTS+1 cycles from start to round_done.
- moveNow and global_writing_flag are never high in the same cycle.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- RESET mid-round aborts immediately: all outputs go to reset values and no partial write is issued. INIT follows release.

## Test plan
- Reset release → global_writing_flag=1 for exactly 1 cycle, then idle. busy=0, moveNow=0.
- N_ANTS=2, ant at (5,5), neighbour E pheromone 0x40, start → reads (5,5),(5,4),(6,4),(6,5)… Required: surrounding_signals[2]=0x40, moveNow at cycle 11 and 23, round_done at cycle 25.
- Ant at (0,0) → NW read address (255,255) and N read (0,255), checking wrap.
- Centre {sugar 3, signal 0xF0}, ant_collecting=1 in MOVE → onSugar=1, write {2, 0xFF} at old position (saturated).
- Centre {sugar 0, signal 0x10}, ant_mouthFull=1 → write {0, 0x30}. With all flags 0 → write {0, 0x10}.
- RESET asserted during READ of ant 1 → no mem_wr_en, outputs go to reset values. start while busy → round length is unchanged.
